// File: rtl/data_memory_ws.sv
// data_memory_ws: single-port word memory with a fixed number of wait states per access.
// Optional macro DMEM_ERR_EN adds an out-of-range err output; without it addresses wrap modulo DEPTH.
module data_memory_ws #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy
`ifdef DMEM_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              access;
  logic              use_in;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_oor;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // With zero wait states the access happens on the request edge itself, straight from the inputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    access  = 1'b0;
    use_in  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            access  = 1'b1;
            use_in  = 1'b1;
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_CYC);
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          access  = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign acc_we    = use_in ? we    : we_q;
  assign acc_addr  = use_in ? addr  : addr_q;
  assign acc_wdata = use_in ? wdata : wdata_q;
  assign acc_be    = use_in ? be    : be_q;
  assign acc_idx   = acc_addr[IDX_W-1:0];

`ifdef DMEM_ERR_EN
  assign acc_oor = (acc_addr >> IDX_W) != '0;
`else
  logic addr_hi_unused;
  assign acc_oor        = 1'b0;
  assign addr_hi_unused = ^(acc_addr >> IDX_W);
`endif

`ifdef DMEM_ERR_EN
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata   <= '0;
`ifdef DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
      if (access) begin
`ifdef DMEM_ERR_EN
        err_q <= acc_oor;
`endif
        if (!acc_we)
          rdata <= acc_oor ? '0 : mem[acc_idx];
      end
    end
  end

  // Storage is never cleared; reset only blocks a write landing on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && access && acc_we && !acc_oor) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i])
          mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
      end
    end
  end

  assign busy  = (state != IDLE);
  assign ready = (state == RESP);
`ifdef DMEM_ERR_EN
  assign err   = (state == RESP) && err_q;
`endif

endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws: drives a WAIT_CYC=2 and a WAIT_CYC=0 instance with the same stimulus
// and compares both against a cycle-level transaction model plus fixed expected vectors.
module tb_data_memory_ws;

  localparam int DEPTH = 1024;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [14:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        ready_a, busy_a, ready_b, busy_b;
  logic [31:0] rdata_a, rdata_b;
`ifdef DMEM_ERR_EN
  logic        err_a, err_b;
`endif

  always #5 clk = ~clk;

  data_memory_ws #(.DATA_W(32), .ADDR_W(15), .DEPTH(DEPTH), .WAIT_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_a), .rdata(rdata_a), .busy(busy_a)
`ifdef DMEM_ERR_EN
    , .err(err_a)
`endif
  );

  data_memory_ws #(.DATA_W(32), .ADDR_W(15), .DEPTH(DEPTH), .WAIT_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_b), .rdata(rdata_b), .busy(busy_b)
`ifdef DMEM_ERR_EN
    , .err(err_b)
`endif
  );

  typedef struct {
    bit          we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
  } vec_t;

  // Transaction model: index 0 mirrors dut_a (2 wait states), index 1 mirrors dut_b (0).
  int          wc [2] = '{2, 0};
  logic [31:0] mref [2][DEPTH];
  logic [31:0] rref [2];
  bit          pend [2];
  int          pend_edge [2];
  int          next_free [2];
  bit          p_we [2];
  logic [14:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_be [2];
  int          edge_n;
  int          ready_a_cnt;
  int          n_checks;
  int          n_pass;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
  endtask

  task automatic model_access(input int i, output bit oor);
    int idx;
    idx = int'(p_addr[i]) % DEPTH;
    oor = ERR_EN && (int'(p_addr[i]) >= DEPTH);
    if (p_we[i]) begin
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (p_be[i][b]) mref[i][idx][b*8 +: 8] = p_wdata[i][b*8 +: 8];
    end else begin
      rref[i] = oor ? 32'h0 : mref[i][idx];
    end
  endtask

  task automatic applyStimulus(input bit r, input bit q, input bit w, input logic [14:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    bit rdy_e [2];
    bit bsy_e [2];
    bit err_e [2];
    bit oor;
    rst = r; req = q; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy_e[i] = 1'b0;
      err_e[i] = 1'b0;
      if (r) begin
        pend[i]      = 1'b0;
        next_free[i] = edge_n + 1;
        rref[i]      = 32'h0;
      end else begin
        if (!pend[i] && edge_n >= next_free[i] && q) begin
          pend[i]      = 1'b1;
          pend_edge[i] = edge_n + wc[i];
          next_free[i] = edge_n + wc[i] + 2;
          p_we[i] = w; p_addr[i] = a; p_wdata[i] = d; p_be[i] = b;
        end
        if (pend[i] && edge_n == pend_edge[i]) begin
          model_access(i, oor);
          pend[i]  = 1'b0;
          rdy_e[i] = 1'b1;
          err_e[i] = oor;
        end
      end
      bsy_e[i] = pend[i] || rdy_e[i];
    end
    if (ready_a) ready_a_cnt++;
    checkOutput("ready_w2", 32'(ready_a), 32'(rdy_e[0]));
    checkOutput("busy_w2",  32'(busy_a),  32'(bsy_e[0]));
    checkOutput("rdata_w2", rdata_a, rref[0]);
    checkOutput("ready_w0", 32'(ready_b), 32'(rdy_e[1]));
    checkOutput("busy_w0",  32'(busy_b),  32'(bsy_e[1]));
    checkOutput("rdata_w0", rdata_b, rref[1]);
`ifdef DMEM_ERR_EN
    checkOutput("err_w2", 32'(err_a), 32'(err_e[0]));
    checkOutput("err_w0", 32'(err_b), 32'(err_e[1]));
`else
    if (err_e[0] || err_e[1]) checkOutput("err_model", 32'h1, 32'h0);
`endif
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 32'h0, 4'h0);
  endtask

  task automatic read_word(input logic [14:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
    idle(3);
  endtask

  vec_t tbl [12];

  initial begin
    n_checks = 0; n_pass = 0; edge_n = 0; ready_a_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pend_edge[i] = 0; next_free[i] = 0; rref[i] = 32'h0;
    end

    tbl[0]  = '{1'b1, 15'd0,    32'h12345678, 4'hF, 32'h00000000};
    tbl[1]  = '{1'b0, 15'd0,    32'h00000000, 4'h0, 32'h12345678};
    tbl[2]  = '{1'b1, 15'd1,    32'hFFFFFFFF, 4'hF, 32'h12345678};
    tbl[3]  = '{1'b1, 15'd1,    32'h00000000, 4'h5, 32'h12345678};
    tbl[4]  = '{1'b0, 15'd1,    32'h00000000, 4'h0, 32'hFF00FF00};
    tbl[5]  = '{1'b1, 15'd0,    32'hDEADBEEF, 4'h0, 32'hFF00FF00};
    tbl[6]  = '{1'b0, 15'd0,    32'h00000000, 4'h0, 32'h12345678};
    tbl[7]  = '{1'b1, 15'd2,    32'h98765432, 4'hF, 32'h12345678};
    tbl[8]  = '{1'b0, 15'd2,    32'h00000000, 4'h0, 32'h98765432};
    tbl[9]  = '{1'b1, 15'd1024, 32'h5A5A5A5A, 4'hF, 32'h98765432};
`ifdef DMEM_ERR_EN
    tbl[10] = '{1'b0, 15'd0,    32'h00000000, 4'h0, 32'h12345678};
    tbl[11] = '{1'b0, 15'd1024, 32'h00000000, 4'h0, 32'h00000000};
`else
    tbl[10] = '{1'b0, 15'd0,    32'h00000000, 4'h0, 32'h5A5A5A5A};
    tbl[11] = '{1'b0, 15'd1024, 32'h00000000, 4'h0, 32'h5A5A5A5A};
`endif

    applyStimulus(1'b1, 1'b1, 1'b1, 15'd3, 32'hFFFFFFFF, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'd0, 32'h0, 4'h0);
    checkOutput("reset_rdata", rdata_a, 32'h0);
    checkOutput("reset_busy", 32'(busy_a), 32'h0);

    // Known contents for every address the later sequences touch.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 15'(i), 32'hC0DE0000 + 32'(i) * 32'h0101, 4'hF);
      idle(3);
    end

    for (int v = 0; v < 12; v++) begin
      applyStimulus(1'b0, 1'b1, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].be);
      idle(3);
      checkOutput($sformatf("tbl%0d_rdata_w2", v), rdata_a, tbl[v].exp_rdata);
      checkOutput($sformatf("tbl%0d_rdata_w0", v), rdata_b, tbl[v].exp_rdata);
    end

    // Reset on the access edge of an in-flight write abandons it.
    read_word(15'd1);
    checkOutput("pre_rst_rdata", rdata_a, 32'hFF00FF00);
    ready_a_cnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 15'd2, 32'hABCDEF01, 4'hF);
    applyStimulus(1'b0, 1'b0, 1'b0, 15'd5, 32'h11111111, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 15'd2, 32'hABCDEF01, 4'hF);
    checkOutput("post_rst_rdata", rdata_a, 32'h0);
    idle(2);
    checkOutput("rst_no_ready", 32'(ready_a_cnt), 32'h0);
    read_word(15'd2);
    checkOutput("rst_write_dropped", rdata_a, 32'h98765432);

    // req held high with a moving address: only IDLE samples count.
    ready_a_cnt = 0;
    for (int c = 0; c < 10; c++)
      applyStimulus(1'b0, 1'b1, 1'b1, 15'(8 + c), 32'hA0000000 + 32'(c), 4'hF);
    idle(4);
    checkOutput("held_req_ready_count", 32'(ready_a_cnt), 32'd3);
    read_word(15'd12);
    checkOutput("held_req_addr12_w2", rdata_a, 32'hA0000004);
    checkOutput("held_req_addr12_w0", rdata_b, 32'hA0000004);
    read_word(15'd9);
    checkOutput("held_req_addr9_w2", rdata_a, 32'hC0DE0909);
    checkOutput("held_req_addr9_w0", rdata_b, 32'hC0DE0909);

    // Zero-wait instance: back-to-back reads every two cycles.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (k % 2 == 0) ? 15'd1 : 15'd4, 32'h0, 4'h0);
      checkOutput($sformatf("b2b_read%0d_w0", k), rdata_b,
                  (k % 2 == 0) ? 32'hFF00FF00 : 32'hC0DE0404);
      idle(1);
    end
    idle(3);

    for (int n = 0; n < 600; n++) begin
      logic [14:0] ra;
      ra = 15'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = ra + 15'(DEPTH * $urandom_range(1, 3));
      applyStimulus($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ra, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
